// File: rtl/seed_pkg.sv
// Shared constants for the byte-serial SEED F-function datapath:
// FSM state encoding, byte-index width and word/frame sizes.
package seed_pkg;

  localparam int WORD_BYTES  = 4;
  localparam int FRAME_BYTES = 8;
  localparam int BIDX_W      = 2;

  // State encoding (plain constants so legacy code can compare raw values)
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LOAD = 3'd1;
  localparam logic [2:0] S_G1   = 3'd2;
  localparam logic [2:0] S_G2   = 3'd3;
  localparam logic [2:0] S_G3   = 3'd4;
  localparam logic [2:0] S_OUT  = 3'd5;

  // Byte j (LSB first) of a 32-bit word
  function automatic logic [7:0] get_byte(input logic [31:0] w, input logic [BIDX_W-1:0] j);
    return w[8*j +: 8];
  endfunction

endpackage

// File: rtl/seed_f_serial_if.sv
// Byte-stream bundle between the F datapath, its producer/consumer and the
// external G function. The slave side is the F datapath itself.
interface seed_f_serial_if;

  logic       in_valid;
  logic [7:0] in_data;
  logic [7:0] k_data;
  logic       in_ready;
  logic       g_in_valid;
  logic [7:0] g_in_data;
  logic       g_out_valid;
  logic [7:0] g_out_data;
  logic       out_valid;
  logic [7:0] out_data;
  logic       err;

  modport master (
    output in_valid, in_data, k_data, g_out_valid, g_out_data,
    input  in_ready, g_in_valid, g_in_data, out_valid, out_data, err
  );

  modport slave (
    input  in_valid, in_data, k_data, g_out_valid, g_out_data,
    output in_ready, g_in_valid, g_in_data, out_valid, out_data, err
  );

endinterface

// File: rtl/seed_byte_adder.sv
// One byte of a serial mod-2^32 addition. The carry register links
// consecutive bytes; i_clr forces a zero carry-in at byte 0 of a word.
module seed_byte_adder (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       i_en,
  input  logic       i_clr,
  input  logic [7:0] i_a,
  input  logic [7:0] i_b,
  output logic [7:0] o_sum
);

  logic       r_carry;
  logic       w_cin;
  logic [8:0] w_full;

  assign w_cin  = i_clr ? 1'b0 : r_carry;
  assign w_full = {1'b0, i_a} + {1'b0, i_b} + {8'd0, w_cin};
  assign o_sum  = w_full[7:0];

  // Keep the carry-out of each consumed byte for the next byte of the word
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  r_carry <= 1'b0;
    else if (i_en) r_carry <= w_full[8];
  end

endmodule

// File: rtl/seed_f_serial.sv
// Byte-serial SEED F function around an external byte-serial G.
// (C,D) and (K0,K1) arrive LSB first; T=C'^D' is streamed to G, then the
// three G results are folded with C', D1 and C2 through one shared adder.
module seed_f_serial
  import seed_pkg::*;
#(
  parameter int G_TIMEOUT = 16
) (
  input  logic           clk,
  input  logic           reset_n,
  seed_f_serial_if.slave bus
);

  localparam int               TMO_W    = $clog2(G_TIMEOUT) + 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(G_TIMEOUT - 1);

  logic [2:0]        r_state;
  logic [2:0]        r_cnt;
  logic [TMO_W-1:0]  r_tmo;
  logic [31:0]       r_cp;
  logic [31:0]       r_d1;
  logic [31:0]       r_c2;
  logic [63:0]       r_out;
  logic              r_g_in_valid;
  logic [7:0]        r_g_in_data;
  logic              r_err;

  logic [BIDX_W-1:0] w_j;
  logic [7:0]        w_in_byte;
  logic [7:0]        w_add_b;
  logic [7:0]        w_sum;
  logic [2:0]        w_next_g;
  logic              w_in_g;
  logic              w_add_en;
  logic              w_add_clr;
  logic              w_word_done;
  logic              w_out_valid;

  assign w_j         = r_cnt[BIDX_W-1:0];
  assign w_in_byte   = bus.in_data ^ bus.k_data;
  assign w_in_g      = (r_state == S_G1) || (r_state == S_G2) || (r_state == S_G3);
  assign w_add_en    = w_in_g && bus.g_out_valid;
  assign w_add_clr   = (w_j == '0);
  assign w_word_done = (w_j == BIDX_W'(WORD_BYTES - 1));
  assign w_out_valid = (r_state == S_OUT);

  // Second adder operand and successor state depend on which G pass is active
  always_comb begin
    w_add_b  = 8'h00;
    w_next_g = S_IDLE;
    case (r_state)
      S_G1: begin w_add_b = get_byte(r_cp, w_j); w_next_g = S_G2;  end
      S_G2: begin w_add_b = get_byte(r_d1, w_j); w_next_g = S_G3;  end
      S_G3: begin w_add_b = get_byte(r_c2, w_j); w_next_g = S_OUT; end
      default: ;
    endcase
  end

  seed_byte_adder u_add (
    .clk     (clk),
    .reset_n (reset_n),
    .i_en    (w_add_en),
    .i_clr   (w_add_clr),
    .i_a     (bus.g_out_data),
    .i_b     (w_add_b),
    .o_sum   (w_sum)
  );

  // Frame sequencing, word storage, G-side strobes and error pulses
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_tmo        <= '0;
      r_cp         <= '0;
      r_d1         <= '0;
      r_c2         <= '0;
      r_out        <= '0;
      r_g_in_valid <= 1'b0;
      r_g_in_data  <= '0;
      r_err        <= 1'b0;
    end else begin
      r_g_in_valid <= 1'b0;
      r_err        <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.g_out_valid) r_err <= 1'b1;
          if (bus.in_valid) begin
            r_cp[7:0] <= w_in_byte;
            r_cnt     <= 3'd1;
            r_state   <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (bus.g_out_valid) r_err <= 1'b1;
          if (!bus.in_valid) begin
            // Input must be gap-free; abandon the frame
            r_err   <= 1'b1;
            r_cnt   <= '0;
            r_state <= S_IDLE;
          end else begin
            if (!r_cnt[2]) begin
              r_cp[8*w_j +: 8] <= w_in_byte;
            end else begin
              r_g_in_valid <= 1'b1;
              r_g_in_data  <= get_byte(r_cp, w_j) ^ w_in_byte;
            end
            if (r_cnt == 3'(FRAME_BYTES - 1)) begin
              r_cnt   <= '0;
              r_tmo   <= '0;
              r_state <= S_G1;
            end else begin
              r_cnt <= r_cnt + 3'd1;
            end
          end
        end
        S_G1, S_G2, S_G3: begin
          if (bus.g_out_valid) begin
            r_tmo <= '0;
            if (r_state == S_G1) begin
              r_d1[8*w_j +: 8] <= bus.g_out_data;
              r_g_in_valid     <= 1'b1;
              r_g_in_data      <= w_sum;
            end else if (r_state == S_G2) begin
              r_c2[8*w_j +: 8] <= bus.g_out_data;
              r_g_in_valid     <= 1'b1;
              r_g_in_data      <= w_sum;
            end else begin
              r_out[32 + 8*w_j +: 8] <= bus.g_out_data;
              r_out[8*w_j +: 8]      <= w_sum;
            end
            if (w_word_done) begin
              r_cnt   <= '0;
              r_state <= w_next_g;
            end else begin
              r_cnt <= r_cnt + 3'd1;
            end
          end else if (r_tmo == TMO_LAST) begin
            r_err   <= 1'b1;
            r_cnt   <= '0;
            r_tmo   <= '0;
            r_state <= S_IDLE;
          end else begin
            r_tmo <= r_tmo + TMO_W'(1);
          end
        end
        S_OUT: begin
          if (bus.g_out_valid) r_err <= 1'b1;
          if (r_cnt == 3'(FRAME_BYTES - 1)) begin
            r_cnt   <= '0;
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + 3'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready   = (r_state == S_IDLE);
  assign bus.g_in_valid = r_g_in_valid;
  assign bus.g_in_data  = r_g_in_data;
  assign bus.out_valid  = w_out_valid;
  assign bus.out_data   = w_out_valid ? r_out[8*r_cnt +: 8] : 8'h00;
  assign bus.err        = r_err;

endmodule
